// File: rtl/serial_byte_receiver.sv
// serial_byte_receiver
//   Rebuilds WIDTH-bit words from an LSB-first serial stream, such as the one a
//   universal shift register emits in right-shift mode. Each completed word is
//   held in ParallelOutput. A ready/acknowledge handshake tells the host when a
//   word is waiting, and sticky flags report overruns and framing errors.
//
//   Handshake (host side): ByteReady=1 means ParallelOutput holds an unread
//   word. The host pulses ReadAck=1 for one cycle to consume it, and ByteReady
//   clears on that edge. If a new word completes on the same edge as ReadAck,
//   ByteReady stays high for the new word. ReadAck has no effect while
//   ByteReady=0.
//
// Ports
//   clk            rising-edge clock
//   clr            asynchronous reset, active-low
//   SerialInput    serial data bit, LSB first
//   ShiftValid     SerialInput carries a valid bit this cycle
//   FrameStart     with ShiftValid: this bit is bit 0 of a new word
//   ReadAck        host consumed ParallelOutput
//   ClearErrors    synchronous clear of Overrun / FrameError
//   ParallelOutput last completed word
//   ByteReady      unread word present
//   Busy           word reception in progress (FSM is in SHIFT)
//   BitCount       bits received so far in the current word
//   Overrun        sticky: a word completed while the previous one was unread
//   FrameError     sticky: FrameStart arrived mid-word
//
// Parameters: WIDTH in 2..16, CW with 2**CW > WIDTH.

module serial_byte_receiver #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             SerialInput,
  input  logic             ShiftValid,
  input  logic             FrameStart,
  input  logic             ReadAck,
  input  logic             ClearErrors,
  output logic [WIDTH-1:0] ParallelOutput,
  output logic             ByteReady,
  output logic             Busy,
  output logic [CW-1:0]    BitCount,
  output logic             Overrun,
  output logic             FrameError
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state,   w_state_nxt;
  logic [WIDTH-1:0] r_sreg,    w_sreg_nxt;
  logic [WIDTH-1:0] r_pout,    w_pout_nxt;
  logic [CW-1:0]    r_count,   w_count_nxt;
  logic             r_ready,   w_ready_nxt;
  logic             r_overrun, w_overrun_nxt;
  logic             r_ferr,    w_ferr_nxt;

  logic [WIDTH-1:0] w_shifted;
  logic             w_last;
  logic             w_complete;
  logic             w_ferr_evt;

  // New bits enter at the top, so the first bit of a word ends up in bit 0.
  assign w_shifted = {SerialInput, r_sreg[WIDTH-1:1]};
  assign w_last    = (r_count == CW'(WIDTH - 1));

  always_comb begin
    w_state_nxt   = r_state;
    w_sreg_nxt    = r_sreg;
    w_pout_nxt    = r_pout;
    w_count_nxt   = r_count;
    w_ready_nxt   = r_ready;
    w_overrun_nxt = r_overrun;
    w_ferr_nxt    = r_ferr;
    w_complete    = 1'b0;
    w_ferr_evt    = 1'b0;

    case (r_state)
      IDLE: begin
        // Bits without FrameStart are ignored here: the receiver waits to
        // lock onto a word boundary.
        if (ShiftValid && FrameStart) begin
          w_sreg_nxt  = w_shifted;
          w_count_nxt = CW'(1);
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (ShiftValid) begin
          w_sreg_nxt = w_shifted;
          if (FrameStart) begin
            // Resynchronise on the new word. The stale partial bits are
            // shifted out before this word can complete.
            w_ferr_evt  = 1'b1;
            w_count_nxt = CW'(1);
          end else if (w_last) begin
            w_complete  = 1'b1;
            w_pout_nxt  = w_shifted;
            w_count_nxt = '0;
            w_state_nxt = IDLE;
          end else begin
            w_count_nxt = r_count + CW'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Completion takes priority over ReadAck, so a word that lands on the
    // acknowledge edge stays flagged as ready.
    if (w_complete)   w_ready_nxt = 1'b1;
    else if (ReadAck) w_ready_nxt = 1'b0;

    // Clear first, then set: an error on the clearing edge still sticks.
    if (ClearErrors) begin
      w_overrun_nxt = 1'b0;
      w_ferr_nxt    = 1'b0;
    end
    if (w_complete && r_ready && !ReadAck) w_overrun_nxt = 1'b1;
    if (w_ferr_evt)                        w_ferr_nxt    = 1'b1;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state   <= IDLE;
      r_sreg    <= '0;
      r_pout    <= '0;
      r_count   <= '0;
      r_ready   <= 1'b0;
      r_overrun <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sreg    <= w_sreg_nxt;
      r_pout    <= w_pout_nxt;
      r_count   <= w_count_nxt;
      r_ready   <= w_ready_nxt;
      r_overrun <= w_overrun_nxt;
      r_ferr    <= w_ferr_nxt;
    end
  end

  assign ParallelOutput = r_pout;
  assign ByteReady      = r_ready;
  assign Busy           = (r_state == SHIFT);
  assign BitCount       = r_count;
  assign Overrun        = r_overrun;
  assign FrameError     = r_ferr;

endmodule

// File: tb/tb_serial_byte_receiver.sv
// Directed testbench for serial_byte_receiver (WIDTH=8, CW=4).
// Inputs change 1 ns after a rising edge; outputs are checked at that point.

module tb_serial_byte_receiver;

  logic       clk;
  logic       clr;
  logic       SerialInput;
  logic       ShiftValid;
  logic       FrameStart;
  logic       ReadAck;
  logic       ClearErrors;
  logic [7:0] ParallelOutput;
  logic       ByteReady;
  logic       Busy;
  logic [3:0] BitCount;
  logic       Overrun;
  logic       FrameError;

  int n_checks;
  int n_errors;

  serial_byte_receiver #(.WIDTH(8), .CW(4)) dut (
    .clk            (clk),
    .clr            (clr),
    .SerialInput    (SerialInput),
    .ShiftValid     (ShiftValid),
    .FrameStart     (FrameStart),
    .ReadAck        (ReadAck),
    .ClearErrors    (ClearErrors),
    .ParallelOutput (ParallelOutput),
    .ByteReady      (ByteReady),
    .Busy           (Busy),
    .BitCount       (BitCount),
    .Overrun        (Overrun),
    .FrameError     (FrameError)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One idle cycle with optional handshake/clear pulses.
  task automatic idle_cycle(input logic ack, input logic clr_err);
    ShiftValid  = 1'b0;
    FrameStart  = 1'b0;
    ReadAck     = ack;
    ClearErrors = clr_err;
    tick();
    ReadAck     = 1'b0;
    ClearErrors = 1'b0;
  endtask

  // Send the low nbits of data LSB first, FrameStart on bit 0. After the
  // accepted-bit counts gap_a / gap_b, the sender stalls for 3 cycles.
  // ack_last raises ReadAck on the edge that samples bit 7.
  task automatic send_word(input logic [7:0] data, input int nbits,
                           input int gap_a, input int gap_b,
                           input logic ack_last, input logic [7:0] prev_pout);
    for (int i = 0; i < nbits; i++) begin
      SerialInput = data[i];
      ShiftValid  = 1'b1;
      FrameStart  = (i == 0);
      ReadAck     = ack_last && (i == 7);
      tick();
      ShiftValid = 1'b0;
      FrameStart = 1'b0;
      ReadAck    = 1'b0;
      if (i < 7) begin
        check("bitcount", BitCount, i + 1);
        check("busy_mid", Busy, 1'b1);
      end
      if ((i + 1) == gap_a || (i + 1) == gap_b) begin
        for (int g = 0; g < 3; g++) begin
          SerialInput = ~SerialInput;
          tick();
          check("gap_bitcount", BitCount, i + 1);
          check("gap_pout", ParallelOutput, prev_pout);
        end
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pout"},  ParallelOutput, 8'h00);
    check({tag, "_ready"}, ByteReady, 1'b0);
    check({tag, "_busy"},  Busy, 1'b0);
    check({tag, "_count"}, BitCount, 4'd0);
    check({tag, "_ovr"},   Overrun, 1'b0);
    check({tag, "_ferr"},  FrameError, 1'b0);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    clr         = 1'b0;
    SerialInput = 1'b0;
    ShiftValid  = 1'b0;
    FrameStart  = 1'b0;
    ReadAck     = 1'b0;
    ClearErrors = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    clr = 1'b1;
    tick();

    // Bits without FrameStart in IDLE are ignored.
    SerialInput = 1'b1;
    ShiftValid  = 1'b1;
    tick();
    tick();
    ShiftValid = 1'b0;
    check("idle_ign_busy",  Busy, 1'b0);
    check("idle_ign_count", BitCount, 4'd0);
    check("idle_ign_ferr",  FrameError, 1'b0);

    // 0xA5 back to back
    send_word(8'hA5, 8, -1, -1, 1'b0, 8'h00);
    check("a5_pout",  ParallelOutput, 8'hA5);
    check("a5_ready", ByteReady, 1'b1);
    check("a5_busy",  Busy, 1'b0);
    check("a5_count", BitCount, 4'd0);
    idle_cycle(1'b1, 1'b0);
    check("a5_ack", ByteReady, 1'b0);
    idle_cycle(1'b1, 1'b0);
    check("ack_noeffect", ByteReady, 1'b0);

    // 0x3C with stalls after bits 2 and 5
    send_word(8'h3C, 8, 2, 5, 1'b0, 8'hA5);
    check("3c_pout",  ParallelOutput, 8'h3C);
    check("3c_ready", ByteReady, 1'b1);
    check("3c_ovr",   Overrun, 1'b0);
    check("3c_ferr",  FrameError, 1'b0);
    idle_cycle(1'b1, 1'b0);

    // 0x11 left unread, then 0xF0 overruns it
    send_word(8'h11, 8, -1, -1, 1'b0, 8'h3C);
    check("11_pout", ParallelOutput, 8'h11);
    check("11_ovr",  Overrun, 1'b0);
    send_word(8'hF0, 8, -1, -1, 1'b0, 8'h11);
    check("f0_pout",  ParallelOutput, 8'hF0);
    check("f0_ready", ByteReady, 1'b1);
    check("f0_ovr",   Overrun, 1'b1);
    idle_cycle(1'b1, 1'b0);
    check("f0_ack",       ByteReady, 1'b0);
    check("ovr_sticky",   Overrun, 1'b1);
    idle_cycle(1'b0, 1'b1);
    check("ovr_cleared",  Overrun, 1'b0);

    // 4 bits of a word, then FrameStart with 0x96
    send_word(8'h0F, 4, -1, -1, 1'b0, 8'hF0);
    check("part_pout", ParallelOutput, 8'hF0);
    check("part_ferr", FrameError, 1'b0);
    send_word(8'h96, 1, -1, -1, 1'b0, 8'hF0);
    check("fs_ferr",  FrameError, 1'b1);
    check("fs_busy",  Busy, 1'b1);
    check("fs_count", BitCount, 4'd1);
    for (int i = 1; i < 8; i++) begin
      SerialInput = 1'(8'h96 >> i);
      ShiftValid  = 1'b1;
      tick();
      ShiftValid  = 1'b0;
    end
    check("96_pout",  ParallelOutput, 8'h96);
    check("96_ready", ByteReady, 1'b1);
    check("96_ferr",  FrameError, 1'b1);
    check("96_ovr",   Overrun, 1'b0);
    idle_cycle(1'b1, 1'b1);
    check("ferr_cleared", FrameError, 1'b0);

    // ReadAck on the completing edge of 0x42 while 0x55 is unread
    send_word(8'h55, 8, -1, -1, 1'b0, 8'h96);
    check("55_ready", ByteReady, 1'b1);
    send_word(8'h42, 8, -1, -1, 1'b1, 8'h55);
    check("42_pout",  ParallelOutput, 8'h42);
    check("42_ready", ByteReady, 1'b1);
    check("42_ovr",   Overrun, 1'b0);
    idle_cycle(1'b1, 1'b0);

    // Asynchronous reset between edges after 5 bits
    send_word(8'hFF, 5, -1, -1, 1'b0, 8'h42);
    #2 clr = 1'b0;
    #1 check_all_zero("async");
    #1 clr = 1'b1;
    tick();
    check("post_rst_busy", Busy, 1'b0);
    send_word(8'h7E, 8, -1, -1, 1'b0, 8'h00);
    check("7e_pout",  ParallelOutput, 8'h7E);
    check("7e_ready", ByteReady, 1'b1);
    check("7e_ovr",   Overrun, 1'b0);
    check("7e_ferr",  FrameError, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_byte_receiver.md
Name: serial_byte_receiver

Overview:
- Deserializer for the LSB-first bit stream that the universal register produces in right-shift mode (serial output = bit 0 on each shift clock).
- Rebuilds WIDTH-bit words and holds each completed word in an output register.
- Signals completion to a host with a ready/acknowledge handshake.
- Flags framing errors and overruns.
- Sits beside the universal register on the datapath, at the receiving end of its serial line.

Parameters:
- WIDTH, 8, bits per word; legal range 2..16.
- CW, 4, bit-counter width; must satisfy 2^CW > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  asynchronous reset, active-low.
- SerialInput  input  1  serial data bit, LSB first.
- ShiftValid  input  1  SerialInput carries a valid bit this cycle (sender is shifting).
- FrameStart  input  1  qualified by ShiftValid: this bit is bit 0 of a new word.
- ReadAck  input  1  host has consumed ParallelOutput; clears ByteReady.
- ClearErrors  input  1  synchronous clear of the sticky error flags.
- ParallelOutput  output  WIDTH  last completed word.
- ByteReady  output  1  unread word present in ParallelOutput.
- Busy  output  1  word reception in progress.
- BitCount  output  CW  bits received in the current word.
- Overrun  output  1  sticky: a word completed while the previous one was unread.
- FrameError  output  1  sticky: FrameStart arrived mid-word.

Behaviour:
- Reset (clr=0, asynchronous, any time including mid-word):
  - State returns to IDLE.
  - Shift register, ParallelOutput, BitCount are all 0.
  - ByteReady, Busy, Overrun, FrameError are all 0.
- Shift rule, applied on every accepted bit: sreg <= {SerialInput, sreg[WIDTH-1:1]}. The first bit received ends in bit 0.
- State machine: IDLE, SHIFT. Busy = (state == SHIFT).
- IDLE:
  - ShiftValid=1 and FrameStart=1: accept the bit, BitCount=1, go to SHIFT.
  - ShiftValid=1 and FrameStart=0: bit is ignored, no error.
  - ShiftValid=0: hold.
- SHIFT:
  - ShiftValid=0: hold all state (stalls of any length are allowed).
  - ShiftValid=1, FrameStart=0, BitCount<WIDTH-1: accept the bit, BitCount+1.
  - ShiftValid=1, FrameStart=0, BitCount==WIDTH-1 (final bit): on the same edge, load ParallelOutput with {SerialInput, sreg[WIDTH-1:1]}, set ByteReady, BitCount=0, go to IDLE.
  - ShiftValid=1, FrameStart=1: set FrameError, discard the partial word, restart with this bit as bit 0 (BitCount=1, stay in SHIFT).
- Latency: ParallelOutput and ByteReady are valid immediately after the edge that samples the final bit. Minimum word interval is WIDTH cycles.
- Handshake:
  - ByteReady stays high until a cycle with ReadAck=1, then clears on that edge.
  - ReadAck while ByteReady=0 has no effect.
  - Completion with ByteReady=1 and ReadAck=0: new word overwrites ParallelOutput, ByteReady stays 1, Overrun set.
  - Completion in the same cycle as ReadAck=1: new word loaded, ByteReady stays 1, no overrun.
- Errors:
  - Overrun and FrameError hold until ClearErrors=1 or reset.
  - If ClearErrors and a new error event occur on the same edge, the flag is set (set wins).
- ParallelOutput changes only on word completion or reset; partial words are never visible on it.
- BitCount never exceeds WIDTH-1 and wraps to 0 only on completion.

Test Plan:
- Reset, then 0xA5 LSB-first on 8 consecutive cycles (bits 1,0,1,0,0,1,0,1, FrameStart on the first bit) -> after the 8th edge ParallelOutput=0xA5, ByteReady=1, Busy=0, BitCount=0.
- 0x3C with ShiftValid deasserted for 3 cycles after bits 2 and 5 -> BitCount holds during the gaps; ParallelOutput=0x3C after the 8th accepted bit, no error flags.
- 0x11 not acknowledged, then 0xF0 completes -> ParallelOutput=0xF0, ByteReady=1, Overrun=1. ReadAck -> ByteReady=0. ClearErrors -> Overrun=0.
- 4 bits sent, then FrameStart with 0x96 -> FrameError=1; ParallelOutput=0x96 after 8 more bits.
- ReadAck on the same edge as 0x42 completes (ByteReady previously 1) -> ParallelOutput=0x42, ByteReady=1, Overrun=0.
- clr pulsed low asynchronously between edges after 5 bits -> all outputs 0 immediately. Next full word 0x7E is received correctly.
